// File: rtl/uart_rx_deframer.sv
// UART receive front end: synchronizes i_rx, deframes 1-start/N-data/1-stop frames into a one-entry holding register.
// Byte appears at the stop-sample edge; a full register raises o_rts_n and a byte completing into it is dropped with o_overrun.
module uart_rx_deframer #(
  parameter int BaudRate             = 9600,
  parameter int SystemClockFrequency = 156250000,
  parameter int DataSize             = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rx,
  output logic [DataSize-1:0] o_rx_data,
  output logic                o_rx_valid,
  input  logic                i_rx_ready,
  output logic                o_rts_n,
  output logic                o_frame_err,
  output logic                o_overrun
);

  localparam int ClksPerBit = SystemClockFrequency / BaudRate;
  localparam int HalfBit    = ClksPerBit / 2;
  localparam int CntW       = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 2;
  localparam int IdxW       = (DataSize > 1) ? $clog2(DataSize) : 1;

  localparam logic [CntW-1:0] CntBitEnd  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] CntHalfEnd = CntW'(HalfBit - 1);
  localparam logic [IdxW-1:0] IdxLast    = IdxW'(DataSize - 1);

  generate
    if (ClksPerBit < 4) begin : g_bad_baud
      $error("uart_rx_deframer: SystemClockFrequency/BaudRate must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic                r_sync1;
  logic                r_sync2;
  logic                w_rx_s;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CntW-1:0]     r_cnt;
  logic [CntW-1:0]     w_cnt_nxt;
  logic [IdxW-1:0]     r_idx;
  logic [IdxW-1:0]     w_idx_nxt;
  logic [DataSize-1:0] r_shift;
  logic [DataSize-1:0] w_shift_nxt;
  logic                w_bit_end;
  logic                w_deliver;
  logic                w_stop_bad;

  logic [DataSize-1:0] r_rx_data;
  logic                r_rx_valid;
  logic                r_rts_n;
  logic                r_frame_err;
  logic                r_overrun;
  logic                w_xfer;
  logic                w_load;
  logic                w_valid_nxt;
  logic                w_drop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  assign w_bit_end = (r_cnt == CntBitEnd);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_deliver   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end
      S_START: begin
        if (r_cnt == CntHalfEnd) begin
          w_cnt_nxt = '0;
          w_idx_nxt = '0;
          // A start bit that is high again at mid-bit was a glitch.
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt                = r_shift >> 1;
          w_shift_nxt[DataSize-1]    = w_rx_s;
          w_cnt_nxt                  = '0;
          if (r_idx == IdxLast) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + IdxW'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_deliver   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end
      S_BREAK: begin
        // Wait for the line to return high so a held-low line cannot retrigger.
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign w_xfer      = r_rx_valid & i_rx_ready;
  assign w_load      = w_deliver & (~r_rx_valid | w_xfer);
  assign w_drop      = w_deliver & r_rx_valid & ~w_xfer;
  assign w_valid_nxt = w_load | (r_rx_valid & ~w_xfer);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_rts_n     <= 1'b1;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        r_rx_data <= r_shift;
      end
      r_rx_valid  <= w_valid_nxt;
      r_rts_n     <= w_valid_nxt;
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_drop;
    end
  end

  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_rts_n     = r_rts_n;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule
